test_monitor: RTL and testbench
===============================

TEST_MONITOR -- requirements
Module: test_monitor

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of pc, gp and store bus.
REQ-002 SHALL have parameter MODE, default 0; 0 = pass-PC/gp detection, 1 = tohost-store detection.
REQ-003 SHALL have parameter PASS_PC, default 32'h44, PC that ends a test in MODE 0.
REQ-004 SHALL have parameter TOHOST_ADDR, default 32'h1000, store address that ends a test in MODE 1.
REQ-005 SHALL have parameter TIMEOUT, default 5000, cycle budget per test (>=2).
REQ-006 SHALL have parameter STALL_LIMIT, default 64, consecutive identical valid PCs that count as a hang (>=2).
REQ-007 clk  input  1  clock; all state updates on rising edge.
REQ-008 rst  input  1  reset, synchronous, active-low.
REQ-009 start  input  1  one-cycle pulse that begins or restarts monitoring.
REQ-010 pc_valid  input  1  pc carries a retiring instruction address this cycle.
REQ-011 pc  input  XLEN  retiring PC.
REQ-012 gp  input  XLEN  current value of register x3.
REQ-013 st_valid  input  1  data-memory store this cycle.
REQ-014 st_addr  input  XLEN  store address.
REQ-015 st_data  input  XLEN  store data.
REQ-016 busy  output  1  monitor in RUN.
REQ-017 done  output  1  monitor in a terminal state (sticky).
REQ-018 status  output  3  0 none, 1 pass, 2 fail, 3 timeout, 4 hang.
REQ-019 test_num  output  XLEN  failing test number (source value >> 1); 0 unless status=2.
REQ-020 cycles  output  32  cycles spent in RUN for the current/last test.

Function
REQ-021 SHALL implement states IDLE, RUN, PASS, FAIL, TIMEOUT, HANG; every output registered.
REQ-022 IDLE -> RUN on start; cycles cleared to 0 on that edge, stall counter cleared, last-PC register cleared.
REQ-023 In RUN, cycles SHALL increment by 1 each clock, saturating at 2^32-1.
REQ-024 MODE 0: pc_valid && pc==PASS_PC SHALL end the test: gp==1 -> PASS; else FAIL with test_num=gp>>1.
REQ-025 MODE 1: st_valid && st_addr==TOHOST_ADDR && st_data[0]==1 SHALL end the test: st_data==1 -> PASS; else FAIL with test_num=st_data>>1; stores with st_data[0]==0 SHALL be ignored.
REQ-026 Stall counter: pc_valid with pc equal to last valid PC increments it; a differing valid pc resets it to 1; pc_valid=0 holds it; reaching STALL_LIMIT -> HANG.
REQ-027 In MODE 0 a repeated pc equal to PASS_PC SHALL terminate as pass/fail, never HANG.
REQ-028 When cycles would reach TIMEOUT with no other terminating event that cycle -> TIMEOUT.
REQ-029 Priority on the same cycle: pass/fail event > HANG > TIMEOUT.
REQ-030 Latency: event sampled on edge N; done, status, test_num valid after edge N (one cycle), busy deasserts on the same edge.
REQ-031 Terminal states SHALL hold all outputs until start or reset; inputs other than start ignored.
REQ-032 start in a terminal state SHALL enter RUN and clear status, test_num, cycles, stall counter on that edge.
REQ-033 start while in RUN SHALL restart the test (same clears as REQ-032); no terminal state reported for the aborted run.
REQ-034 MODE is static; events of the unselected mode SHALL have no effect.

Reset
REQ-035 On rising clk with rst=0: state IDLE, busy=0, done=0, status=0, test_num=0, cycles=0, counters and last-PC cleared.
REQ-036 Reset SHALL override start and every event on the same edge, including mid-test.

Verification
REQ-037 MODE 0: start, pc sequence 0,4,8,...,0x44 with gp=1 at 0x44 -> next cycle done=1, status=1, test_num=0, busy=0.
REQ-038 MODE 0: pc=0x44 with gp=7 -> status=2, test_num=3; outputs held for 100 further cycles of random pc/gp.
REQ-039 MODE 1: store to 0x1000 data 2 (ignored), then data 11 -> status=2, test_num=5; separate run with data 1 -> status=1.
REQ-040 TIMEOUT=20, never-matching pc incrementing each cycle -> status=3 exactly 20 cycles after start, cycles=20.
REQ-041 STALL_LIMIT=4, pc held at 0x100 with pc_valid=1 -> status=4 after 4th valid 0x100; with pc_valid toggling, HANG delayed accordingly.
REQ-042 rst=0 mid-RUN, then start -> all outputs 0 after reset, new run counts cycles from 0; pass event coincident with timeout cycle -> status=1.

Source files
------------

// File: rtl/test_monitor.sv
// ============================================================================
//  Module   : test_monitor
//  Purpose  : Watches a core's retire/store streams and reports pass, fail,
//             timeout or hang for a self-checking ISA test.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module test_monitor #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     MODE        = 0,
  parameter logic [XLEN-1:0] PASS_PC     = XLEN'(32'h44),
  parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(32'h1000),
  parameter int unsigned     TIMEOUT     = 5000,
  parameter int unsigned     STALL_LIMIT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            pc_valid,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] gp,
  input  logic            st_valid,
  input  logic [XLEN-1:0] st_addr,
  input  logic [XLEN-1:0] st_data,
  output logic            busy,
  output logic            done,
  output logic [2:0]      status,
  output logic [XLEN-1:0] test_num,
  output logic [31:0]     cycles
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RUN     = 3'd1;
  localparam logic [2:0] ST_PASS    = 3'd2;
  localparam logic [2:0] ST_FAIL    = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;
  localparam logic [2:0] ST_HANG    = 3'd5;

  localparam logic [2:0] c_STAT_NONE    = 3'd0;
  localparam logic [2:0] c_STAT_PASS    = 3'd1;
  localparam logic [2:0] c_STAT_FAIL    = 3'd2;
  localparam logic [2:0] c_STAT_TIMEOUT = 3'd3;
  localparam logic [2:0] c_STAT_HANG    = 3'd4;

  localparam logic [31:0]     c_CYC_MAX = 32'hFFFF_FFFF;
  localparam logic [31:0]     c_TIMEOUT = 32'(TIMEOUT);
  localparam logic [31:0]     c_STALL   = 32'(STALL_LIMIT);
  localparam logic [XLEN-1:0] c_ONE     = XLEN'(1);

  logic [2:0]      r_state;
  logic            r_busy;
  logic            r_done;
  logic [2:0]      r_status;
  logic [XLEN-1:0] r_test_num;
  logic [31:0]     r_cycles;
  logic [31:0]     r_stall;
  logic [XLEN-1:0] r_last_pc;

  logic            w_end;
  logic [XLEN-1:0] w_end_val;
  logic [31:0]     w_cyc_next;
  logic [31:0]     w_stall_next;
  logic            w_hang;
  logic            w_timeout;

  // The end-of-test event and the value it reports depend on the static MODE.
  always_comb begin
    w_end     = 1'b0;
    w_end_val = gp;
    if (MODE == 0) begin
      w_end     = pc_valid && (pc == PASS_PC);
      w_end_val = gp;
    end else begin
      w_end     = st_valid && (st_addr == TOHOST_ADDR) && st_data[0];
      w_end_val = st_data;
    end
  end

  always_comb begin
    w_cyc_next   = (r_cycles == c_CYC_MAX) ? r_cycles : r_cycles + 32'd1;
    w_stall_next = (pc == r_last_pc) ? r_stall + 32'd1 : 32'd1;
    w_hang       = pc_valid && (w_stall_next >= c_STALL);
    w_timeout    = (w_cyc_next == c_TIMEOUT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_status   <= c_STAT_NONE;
      r_test_num <= '0;
      r_cycles   <= '0;
      r_stall    <= '0;
      r_last_pc  <= '0;
    end else if (start) begin
      // Start behaves identically from IDLE, RUN (abort) or any terminal state.
      r_state    <= ST_RUN;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
      r_status   <= c_STAT_NONE;
      r_test_num <= '0;
      r_cycles   <= '0;
      r_stall    <= '0;
      r_last_pc  <= '0;
    end else if (r_state == ST_RUN) begin
      r_cycles <= w_cyc_next;
      if (pc_valid) begin
        r_last_pc <= pc;
        r_stall   <= w_stall_next;
      end
      if (w_end) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
        if (w_end_val == c_ONE) begin
          r_state  <= ST_PASS;
          r_status <= c_STAT_PASS;
        end else begin
          r_state    <= ST_FAIL;
          r_status   <= c_STAT_FAIL;
          r_test_num <= w_end_val >> 1;
        end
      end else if (w_hang) begin
        r_state  <= ST_HANG;
        r_busy   <= 1'b0;
        r_done   <= 1'b1;
        r_status <= c_STAT_HANG;
      end else if (w_timeout) begin
        r_state  <= ST_TIMEOUT;
        r_busy   <= 1'b0;
        r_done   <= 1'b1;
        r_status <= c_STAT_TIMEOUT;
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign status   = r_status;
  assign test_num = r_test_num;
  assign cycles   = r_cycles;

endmodule

`default_nettype wire

// File: tb/tb_test_monitor.sv
// Bench for test_monitor: one instance per MODE sharing stimulus, checked against
// a queue-based reference model plus a vector table and directed corner cases.
`default_nettype none

module tb_test_monitor;

  logic        clk = 1'b0;
  logic        rst, start, pc_valid, st_valid;
  logic [31:0] pc, gp, st_addr, st_data;

  logic        busy0, done0, busy1, done1;
  logic [2:0]  status0, status1;
  logic [31:0] tn0, tn1, cyc0, cyc1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  test_monitor #(.XLEN(32), .MODE(0), .PASS_PC(32'h44), .TOHOST_ADDR(32'h1000),
                 .TIMEOUT(20), .STALL_LIMIT(4)) dut0 (
    .clk(clk), .rst(rst), .start(start), .pc_valid(pc_valid), .pc(pc), .gp(gp),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .busy(busy0), .done(done0), .status(status0), .test_num(tn0), .cycles(cyc0));

  test_monitor #(.XLEN(32), .MODE(1), .PASS_PC(32'h44), .TOHOST_ADDR(32'h1000),
                 .TIMEOUT(20), .STALL_LIMIT(4)) dut1 (
    .clk(clk), .rst(rst), .start(start), .pc_valid(pc_valid), .pc(pc), .gp(gp),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .busy(busy1), .done(done1), .status(status1), .test_num(tn1), .cycles(cyc1));

  // Reference model: index 0 = MODE 0, index 1 = MODE 1
  logic        m_busy[2];
  logic        m_done[2];
  logic [2:0]  m_st[2];
  logic [31:0] m_tn[2];
  logic [31:0] m_cyc[2];
  logic [31:0] pcq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int          rl;
    logic        ev;
    logic [31:0] v;
    if (!rst) begin
      for (int m = 0; m < 2; m++) begin
        m_busy[m] = 0; m_done[m] = 0; m_st[m] = 0; m_tn[m] = 0; m_cyc[m] = 0;
      end
      pcq.delete();
    end else if (start) begin
      for (int m = 0; m < 2; m++) begin
        m_busy[m] = 1; m_done[m] = 0; m_st[m] = 0; m_tn[m] = 0; m_cyc[m] = 0;
      end
      pcq.delete();
    end else begin
      rl = 0;
      if (pc_valid) begin
        pcq.push_back(pc);
        if (pcq.size() > 16) void'(pcq.pop_front());
        for (int k = pcq.size() - 1; k >= 0; k--) begin
          if (pcq[k] != pc) break;
          rl++;
        end
      end
      for (int m = 0; m < 2; m++) begin
        if (m_busy[m]) begin
          if (m_cyc[m] != 32'hFFFF_FFFF) m_cyc[m]++;
          ev = (m == 0) ? (pc_valid && pc == 32'h44)
                        : (st_valid && st_addr == 32'h1000 && st_data[0]);
          v  = (m == 0) ? gp : st_data;
          if (ev) begin
            m_busy[m] = 0; m_done[m] = 1;
            m_st[m] = (v == 1) ? 3'd1 : 3'd2;
            m_tn[m] = (v == 1) ? 32'd0 : v / 2;
          end else if (pc_valid && rl >= 4) begin
            m_busy[m] = 0; m_done[m] = 1; m_st[m] = 3'd4;
          end else if (m_cyc[m] == 20) begin
            m_busy[m] = 0; m_done[m] = 1; m_st[m] = 3'd3;
          end
        end
      end
    end
  endtask

  task automatic check_model();
    chk("m0.busy", 32'(busy0), 32'(m_busy[0]));
    chk("m0.done", 32'(done0), 32'(m_done[0]));
    chk("m0.status", 32'(status0), 32'(m_st[0]));
    chk("m0.test_num", tn0, m_tn[0]);
    chk("m0.cycles", cyc0, m_cyc[0]);
    chk("m1.busy", 32'(busy1), 32'(m_busy[1]));
    chk("m1.done", 32'(done1), 32'(m_done[1]));
    chk("m1.status", 32'(status1), 32'(m_st[1]));
    chk("m1.test_num", tn1, m_tn[1]);
    chk("m1.cycles", cyc1, m_cyc[1]);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic drive(input logic s, input logic pv, input logic [31:0] p, input logic [31:0] g,
                       input logic sv, input logic [31:0] sa, input logic [31:0] sd);
    start = s; pc_valid = pv; pc = p; gp = g; st_valid = sv; st_addr = sa; st_data = sd;
  endtask

  typedef struct {
    logic        start;
    logic        pcv;
    logic [31:0] pc;
    logic [31:0] gp;
    logic        busy;
    logic        done;
    logic [2:0]  status;
    logic [31:0] tn;
    logic [31:0] cyc;
  } vec_t;

  function automatic vec_t mk(logic s, logic pv, logic [31:0] p, logic [31:0] g,
                              logic b, logic d, logic [2:0] st, logic [31:0] t, logic [31:0] c);
    vec_t r;
    r.start = s; r.pcv = pv; r.pc = p; r.gp = g;
    r.busy = b; r.done = d; r.status = st; r.tn = t; r.cyc = c;
    return r;
  endfunction

  vec_t vt[15];

  initial begin
    // MODE 0 vectors: {start, pc_valid, pc, gp} -> {busy, done, status, test_num, cycles}
    vt[0]  = mk(1, 0, 32'h0,   0, 1, 0, 0, 0, 0);
    vt[1]  = mk(0, 1, 32'h0,   0, 1, 0, 0, 0, 1);
    vt[2]  = mk(0, 1, 32'h0,   0, 1, 0, 0, 0, 2);
    vt[3]  = mk(0, 1, 32'h4,   0, 1, 0, 0, 0, 3);
    vt[4]  = mk(0, 1, 32'h44,  7, 0, 1, 2, 3, 4);
    vt[5]  = mk(0, 1, 32'h100, 0, 0, 1, 2, 3, 4);
    vt[6]  = mk(1, 0, 32'h0,   0, 1, 0, 0, 0, 0);
    vt[7]  = mk(0, 1, 32'h44,  1, 0, 1, 1, 0, 1);
    vt[8]  = mk(1, 0, 32'h0,   0, 1, 0, 0, 0, 0);
    vt[9]  = mk(0, 1, 32'h100, 0, 1, 0, 0, 0, 1);
    vt[10] = mk(0, 1, 32'h100, 0, 1, 0, 0, 0, 2);
    vt[11] = mk(0, 1, 32'h100, 0, 1, 0, 0, 0, 3);
    vt[12] = mk(0, 1, 32'h100, 0, 0, 1, 4, 0, 4);
    vt[13] = mk(1, 0, 32'h0,   0, 1, 0, 0, 0, 0);
    vt[14] = mk(0, 0, 32'h0,   0, 1, 0, 0, 0, 1);

    rst = 1'b0;
    drive(1, 1, 32'h44, 1, 1, 32'h1000, 1);
    tick();
    tick();
    chk("reset.busy", 32'(busy0), 0);
    chk("reset.done", 32'(done0), 0);
    chk("reset.status", 32'(status0), 0);
    chk("reset.cycles", cyc0, 0);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();

    for (int i = 0; i < 15; i++) begin
      drive(vt[i].start, vt[i].pcv, vt[i].pc, vt[i].gp, 0, 0, 0);
      tick();
      chk($sformatf("vec%0d.busy", i), 32'(busy0), 32'(vt[i].busy));
      chk($sformatf("vec%0d.done", i), 32'(done0), 32'(vt[i].done));
      chk($sformatf("vec%0d.status", i), 32'(status0), 32'(vt[i].status));
      chk($sformatf("vec%0d.test_num", i), tn0, vt[i].tn);
      chk($sformatf("vec%0d.cycles", i), cyc0, vt[i].cyc);
    end

    // Pass-PC walk 0,4,...,0x44
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i <= 17; i++) begin
      drive(0, 1, 32'(i * 4), (i == 17) ? 32'd1 : 32'd0, 0, 0, 0);
      tick();
    end
    chk("walk.done", 32'(done0), 1);
    chk("walk.status", 32'(status0), 1);
    chk("walk.test_num", tn0, 0);
    chk("walk.busy", 32'(busy0), 0);

    // Fail with gp=7, then hold through random traffic
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 32'h44, 7, 0, 0, 0); tick();
    for (int i = 0; i < 100; i++) begin
      drive(0, 1'($urandom), $urandom_range(0, 1) ? 32'h44 : $urandom, $urandom_range(0, 3),
            1'($urandom), 32'h1000, $urandom_range(0, 15));
      tick();
      chk("hold.status", 32'(status0), 2);
      chk("hold.test_num", tn0, 3);
    end

    // tohost stores: even data ignored, odd data ends the test
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 32'h1000, 2); tick();
    chk("tohost.even.busy", 32'(busy1), 1);
    drive(0, 0, 0, 0, 1, 32'h1000, 11); tick();
    chk("tohost.fail.status", 32'(status1), 2);
    chk("tohost.fail.test_num", tn1, 5);
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 32'h1000, 1); tick();
    chk("tohost.pass.status", 32'(status1), 1);

    // Timeout with a never-matching incrementing pc
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 32'h200 + 32'(i * 4), 0, 0, 0, 0);
      tick();
      if (i == 18) chk("timeout.pre.busy", 32'(busy0), 1);
    end
    chk("timeout.status", 32'(status0), 3);
    chk("timeout.cycles", cyc0, 20);
    chk("timeout.m1.status", 32'(status1), 3);

    // Hang with pc_valid toggling: 4th valid 0x100 arrives on the 7th cycle
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 7; i++) begin
      drive(0, (i % 2) == 0, 32'h100, 0, 0, 0, 0);
      tick();
      if (i == 5) chk("hang.toggle.pre.busy", 32'(busy0), 1);
    end
    chk("hang.toggle.status", 32'(status0), 4);
    chk("hang.toggle.cycles", cyc0, 7);

    // Reset mid-run overrides start and a coincident pass event
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin drive(0, 1, 32'h500 + 32'(i * 4), 0, 0, 0, 0); tick(); end
    rst = 1'b0;
    drive(1, 1, 32'h44, 1, 1, 32'h1000, 1); tick();
    chk("midrst.busy", 32'(busy0), 0);
    chk("midrst.status", 32'(status0), 0);
    chk("midrst.cycles", cyc0, 0);
    rst = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    chk("midrst.restart.cycles", cyc0, 1);

    // Pass event on the timeout cycle wins
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 19; i++) begin drive(0, 1, 32'h300 + 32'(i * 4), 0, 0, 0, 0); tick(); end
    chk("coinc.pre.busy", 32'(busy0), 1);
    drive(0, 1, 32'h44, 1, 1, 32'h1000, 1); tick();
    chk("coinc.m0.status", 32'(status0), 1);
    chk("coinc.m0.cycles", cyc0, 20);
    chk("coinc.m1.status", 32'(status1), 1);

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      logic [31:0] p;
      case ($urandom_range(0, 3))
        0:       p = 32'h44;
        1:       p = 32'h100;
        2:       p = 32'h104;
        default: p = $urandom & 32'hFFFF_FFFC;
      endcase
      rst = ($urandom_range(0, 63) != 0);
      drive($urandom_range(0, 15) == 0, 1'($urandom), p,
            $urandom_range(0, 1) ? 32'd1 : 32'($urandom_range(0, 31)),
            1'($urandom), $urandom_range(0, 1) ? 32'h1000 : 32'h2000,
            32'($urandom_range(0, 15)));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
